// File: rtl/pipe_addsub_pkg.sv
// Shared types and elaboration helpers for the pipelined adder/subtractor.
package pipe_addsub_pkg;

   typedef struct packed {
      logic cout;
      logic zero;
      logic neg;
      logic ovf;
   } flags_t;

   function automatic int unsigned chunk_w(input int unsigned width, input int unsigned stages);
      return (stages == 0) ? width : width / stages;
   endfunction

   function automatic bit cfg_ok(input int unsigned width, input int unsigned stages);
      return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
   endfunction

endpackage

// File: rtl/pipe_addsub_add_chunk.sv
// Combinational W-bit ripple adder; c_msb is the carry into bit W-1.
module add_chunk #(
   parameter int unsigned W = 8
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         ci,
   output logic [W-1:0] s,
   output logic         co,
   output logic         c_msb
);

   always_comb begin
      logic [W:0] c;
      c     = '0;
      s     = '0;
      c[0]  = ci;
      for (int unsigned i = 0; i < W; i++) begin
         s[i]   = a[i] ^ b[i] ^ c[i];
         c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
      end
      co    = c[W];
      c_msb = c[W-1];
   end

endmodule

// File: rtl/pipe_addsub.sv
// Pipelined two's-complement add/sub: one CHUNK resolved per stage, single stall enable.
module pipe_addsub
   import pipe_addsub_pkg::*;
#(
   parameter int unsigned WIDTH  = 32,
   parameter int unsigned STAGES = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             zero,
   output logic             neg,
   output logic             ovf
);

   localparam int unsigned CHUNK = chunk_w(WIDTH, STAGES);

   if (!cfg_ok(WIDTH, STAGES)) begin : g_cfg_err
      $error("pipe_addsub: WIDTH must be a multiple of STAGES and 1 <= STAGES <= WIDTH");
   end

   logic             adv;
   logic             v_in   [STAGES];
   logic             ci_in  [STAGES];
   logic [WIDTH-1:0] acc_in [STAGES];
   logic [WIDTH-1:0] bop_in [STAGES];
   logic [CHUNK-1:0] s_c    [STAGES];
   logic             co_c   [STAGES];
   logic             cm_c   [STAGES];
   logic [WIDTH-1:0] acc_d  [STAGES];
   logic [WIDTH-1:0] bop_d  [STAGES];

   // acc_q: low bits hold the sum so far, high bits the A chunks not yet consumed.
   // bop_q: B (already conditioned for subtract) chunks not yet consumed, right-aligned.
   logic             v_q    [STAGES];
   logic             c_q    [STAGES];
   logic [WIDTH-1:0] acc_q  [STAGES];
   logic [WIDTH-1:0] bop_q  [STAGES];
   flags_t           flags_d;
   flags_t           flags_q;

   assign adv      = !v_q[STAGES-1] || out_ready;
   assign in_ready = adv;

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      localparam int unsigned      LO   = k * CHUNK;
      localparam logic [WIDTH-1:0] MASK = WIDTH'({CHUNK{1'b1}}) << LO;

      if (k == 0) begin : g_head
         assign v_in[k]   = in_valid;
         assign ci_in[k]  = cin ^ sub;
         assign acc_in[k] = a;
         assign bop_in[k] = sub ? ~b : b;
      end else begin : g_body
         assign v_in[k]   = v_q[k-1];
         assign ci_in[k]  = c_q[k-1];
         assign acc_in[k] = acc_q[k-1];
         assign bop_in[k] = bop_q[k-1];
      end

      add_chunk #(.W(CHUNK)) u_add (
         .a     (acc_in[k][LO +: CHUNK]),
         .b     (bop_in[k][CHUNK-1:0]),
         .ci    (ci_in[k]),
         .s     (s_c[k]),
         .co    (co_c[k]),
         .c_msb (cm_c[k])
      );

      assign acc_d[k] = (acc_in[k] & ~MASK) | (WIDTH'(s_c[k]) << LO);
      assign bop_d[k] = bop_in[k] >> CHUNK;
   end

   // Status flags of the fully resolved sum, captured alongside the last stage.
   always_comb begin
      flags_d      = '0;
      flags_d.cout = co_c[STAGES-1];
      flags_d.zero = (acc_d[STAGES-1] == '0);
      flags_d.neg  = acc_d[STAGES-1][WIDTH-1];
      flags_d.ovf  = cm_c[STAGES-1] ^ co_c[STAGES-1];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned k = 0; k < STAGES; k++) begin
            v_q[k]   <= 1'b0;
            c_q[k]   <= 1'b0;
            acc_q[k] <= '0;
            bop_q[k] <= '0;
         end
         flags_q <= '0;
      end else if (adv) begin
         for (int unsigned k = 0; k < STAGES; k++) begin
            v_q[k]   <= v_in[k];
            c_q[k]   <= co_c[k];
            acc_q[k] <= acc_d[k];
            bop_q[k] <= bop_d[k];
         end
         flags_q <= flags_d;
      end
   end

   assign out_valid = v_q[STAGES-1];
   assign sum       = acc_q[STAGES-1];
   assign cout      = flags_q.cout;
   assign zero      = flags_q.zero;
   assign neg       = flags_q.neg;
   assign ovf       = flags_q.ovf;

endmodule

// File: tb/tb_pipe_addsub.sv
// Scoreboard bench for pipe_addsub: directed corner vectors, back-pressure, random traffic, reset.
module tb_pipe_addsub;

   localparam int unsigned WIDTH  = 32;
   localparam int unsigned STAGES = 4;

   typedef struct {
      logic [WIDTH-1:0] sum;
      logic             cout;
      logic             zero;
      logic             neg;
      logic             ovf;
      bit               lat_chk;
      int               t_in;
   } exp_t;

   logic             clk       = 1'b0;
   logic             rst_n     = 1'b0;
   logic             in_valid  = 1'b0;
   logic             in_ready;
   logic [WIDTH-1:0] a         = '0;
   logic [WIDTH-1:0] b         = '0;
   logic             sub       = 1'b0;
   logic             cin       = 1'b0;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             zero;
   logic             neg;
   logic             ovf;

   int               checks   = 0;
   int               failures = 0;
   int               cyc      = 0;
   int               n_out    = 0;
   bit               chk_lat  = 1'b0;
   bit               rand_rdy = 1'b0;
   exp_t             q[$];
   exp_t             mon_e;
   bit               prev_hold = 1'b0;
   logic [WIDTH-1:0] prev_sum  = '0;
   logic [3:0]       prev_fl   = '0;

   pipe_addsub #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .sub       (sub),
      .cin       (cin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
      .zero      (zero),
      .neg       (neg),
      .ovf       (ovf)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      if (rand_rdy) begin
         #1;
         out_ready = 1'($urandom_range(1, 0));
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
      end
   endtask

   // Reference: signed/unsigned integer arithmetic on the operands themselves.
   function automatic exp_t model(input logic [31:0] av, input logic [31:0] bv,
                                  input logic sv, input logic cv);
      exp_t   r;
      longint sa, sb, ua, ub, c, res;
      sa  = longint'($signed(av));
      sb  = longint'($signed(bv));
      ua  = longint'({1'b0, av});
      ub  = longint'({1'b0, bv});
      c   = cv ? 64'sd1 : 64'sd0;
      res = sv ? (sa - sb - c) : (sa + sb + c);
      r.sum     = res[31:0];
      r.cout    = sv ? (ua >= ub + c) : ((ua + ub + c) >= 64'sd4294967296);
      r.zero    = (r.sum == 32'h0);
      r.neg     = r.sum[31];
      r.ovf     = (res > 64'sd2147483647) || (res < -64'sd2147483648);
      r.lat_chk = 1'b0;
      r.t_in    = 0;
      return r;
   endfunction

   function automatic exp_t mk(input logic [31:0] s, input logic c, input logic z,
                               input logic n, input logic o);
      exp_t r;
      r.sum = s; r.cout = c; r.zero = z; r.neg = n; r.ovf = o;
      r.lat_chk = 1'b0;
      r.t_in    = 0;
      return r;
   endfunction

   function automatic logic [31:0] rnd_op();
      case ($urandom_range(7, 0))
         0:       return 32'h0000_0000;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h7FFF_FFFF;
         3:       return 32'h8000_0000;
         default: return 32'($urandom);
      endcase
   endfunction

   // Call just after a rising edge; returns just after the edge that took the beat.
   task automatic send_beat(input logic [31:0] av, input logic [31:0] bv, input logic sv,
                            input logic cv, input bit dir, input exp_t de);
      int   waited;
      exp_t e;
      waited   = 0;
      a        = av;
      b        = bv;
      sub      = sv;
      cin      = cv;
      in_valid = 1'b1;
      @(negedge clk);
      while (!in_ready && waited < 1000) begin
         @(negedge clk);
         waited++;
      end
      if (!in_ready) begin
         checks++;
         failures++;
         $display("FAIL accept_timeout: in_ready stayed 0 for %0d cycles", waited);
         in_valid = 1'b0;
         return;
      end
      e         = dir ? de : model(av, bv, sv, cv);
      e.t_in    = cyc;
      e.lat_chk = chk_lat;
      q.push_back(e);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_drain(input int budget);
      int n;
      n = 0;
      while (q.size() != 0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (q.size() != 0) begin
         failures++;
         $display("FAIL drain_timeout: %0d beats outstanding after %0d cycles", q.size(), budget);
         q.delete();
      end
      @(posedge clk);
      #1;
   endtask

   // Output monitor: hold-stability while stalled, then in-order scoreboard pop.
   always @(negedge clk) begin
      if (!rst_n) begin
         prev_hold = 1'b0;
      end else begin
         if (prev_hold) begin
            check("hold_valid", 64'(out_valid), 64'd1);
            check("hold_sum", 64'(sum), 64'(prev_sum));
            check("hold_flags", 64'({cout, zero, neg, ovf}), 64'(prev_fl));
         end
         if (out_valid && !out_ready)
            check("stall_in_ready", 64'(in_ready), 64'd0);
         prev_hold = out_valid && !out_ready;
         prev_sum  = sum;
         prev_fl   = {cout, zero, neg, ovf};
         if (out_valid && out_ready) begin
            n_out++;
            if (q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_output: got sum 0x%0h with no beat outstanding", sum);
            end else begin
               mon_e = q.pop_front();
               check("sum", 64'(sum), 64'(mon_e.sum));
               check("flags{cout,zero,neg,ovf}", 64'({cout, zero, neg, ovf}),
                     64'({mon_e.cout, mon_e.zero, mon_e.neg, mon_e.ovf}));
               if (mon_e.lat_chk)
                  check("latency", 64'(cyc - mon_e.t_in), 64'(STAGES));
            end
         end
      end
   end

   initial begin
      int   n0;
      int   n;
      exp_t dummy;
      dummy = mk(32'h0, 1'b0, 1'b0, 1'b0, 1'b0);

      #12;
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_sum", 64'(sum), 64'd0);
      check("rst_flags", 64'({cout, zero, neg, ovf}), 64'd0);
      check("rst_in_ready", 64'(in_ready), 64'd1);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      check("release_in_ready", 64'(in_ready), 64'd1);

      // Directed corners on an empty pipe, latency checked.
      chk_lat = 1'b1;
      send_beat(32'h0000_0005, 32'h0000_0003, 1'b0, 1'b0, 1'b1, mk(32'h0000_0008, 0, 0, 0, 0));
      wait_drain(20);
      send_beat(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b1, mk(32'h0000_0000, 1, 1, 0, 0));
      wait_drain(20);
      send_beat(32'h0000_0003, 32'h0000_0005, 1'b1, 1'b0, 1'b1, mk(32'hFFFF_FFFE, 0, 0, 1, 0));
      wait_drain(20);
      send_beat(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0, 1'b1, mk(32'h7FFF_FFFF, 1, 0, 0, 1));
      wait_drain(20);
      send_beat(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b1, mk(32'h8000_0000, 0, 0, 1, 1));
      wait_drain(20);
      send_beat(32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1, 1'b1, mk(32'h0000_0001, 0, 0, 0, 0));
      wait_drain(20);
      send_beat(32'h0000_0005, 32'h0000_0005, 1'b1, 1'b1, 1'b1, mk(32'hFFFF_FFFF, 0, 0, 1, 0));
      wait_drain(20);
      send_beat(32'h0000_0005, 32'h0000_0005, 1'b1, 1'b0, 1'b1, mk(32'h0000_0000, 1, 1, 0, 0));
      wait_drain(20);
      send_beat(32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b1, mk(32'h0001_0000, 0, 0, 0, 0));
      wait_drain(20);
      chk_lat = 1'b0;

      // Eight back-to-back beats with a six-cycle output stall in the middle.
      n0 = n_out;
      fork
         begin
            for (int i = 0; i < 8; i++)
               send_beat(rnd_op(), rnd_op(), 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)),
                         1'b0, dummy);
         end
         begin
            repeat (5) @(posedge clk);
            #1;
            out_ready = 1'b0;
            repeat (3) @(negedge clk);
            check("bp_out_valid", 64'(out_valid), 64'd1);
            check("bp_in_ready", 64'(in_ready), 64'd0);
            repeat (4) @(posedge clk);
            #1;
            out_ready = 1'b1;
         end
      join
      wait_drain(100);
      check("bp_count", 64'(n_out - n0), 64'd8);

      // Random valid/ready traffic.
      rand_rdy = 1'b1;
      for (int i = 0; i < 10000; i++) begin
         while ($urandom_range(1, 0) == 0) begin
            @(posedge clk);
            #1;
         end
         send_beat(rnd_op(), rnd_op(), 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)),
                   1'b0, dummy);
      end
      rand_rdy = 1'b0;
      @(posedge clk);
      #2;
      out_ready = 1'b1;
      wait_drain(200);

      // Asynchronous reset with three beats in flight, one held at the output.
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++)
         send_beat(rnd_op(), rnd_op(), 1'b0, 1'b0, 1'b0, dummy);
      n = 0;
      while (!out_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("flight_out_valid", 64'(out_valid), 64'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("mid_rst_out_valid", 64'(out_valid), 64'd0);
      check("mid_rst_sum", 64'(sum), 64'd0);
      check("mid_rst_flags", 64'({cout, zero, neg, ovf}), 64'd0);
      check("mid_rst_in_ready", 64'(in_ready), 64'd1);
      q.delete();
      n0 = n_out;
      repeat (2) @(posedge clk);
      #3;
      rst_n     = 1'b1;
      out_ready = 1'b1;
      check("post_rst_in_ready", 64'(in_ready), 64'd1);
      repeat (12) @(negedge clk);
      check("post_rst_no_stale", 64'(n_out - n0), 64'd0);
      check("post_rst_out_valid", 64'(out_valid), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pipe_addsub.md
Name: pipe_addsub

Overview:
- Parametrised, pipelined two's-complement adder/subtractor with status flags. It is the next-generation replacement for the fixed 16-bit ripple-carry adder.
- Operands are split into STAGES equal chunks. Each pipeline stage ripples one chunk and registers the carry into the next stage.
- Valid/ready handshakes on both sides let it sit between a register-file read port and a writeback queue.

Parameters:
- WIDTH, 32, operand/result width in bits; must be a multiple of STAGES.
- STAGES, 4, pipeline depth; CHUNK = WIDTH/STAGES bits are resolved per stage. Legal range is 1..WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand beat valid
- in_ready  output  1  block can accept a beat this cycle
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- sub  input  1  0: A+B+cin; 1: A-B-cin (cin acts as borrow-in)
- cin  input  1  carry/borrow in
- out_valid  output  1  result beat valid
- out_ready  input  1  consumer accepts result
- sum  output  WIDTH  result
- cout  output  1  carry out; for sub, 1 = no borrow
- zero  output  1  sum == 0
- neg  output  1  sum[WIDTH-1]
- ovf  output  1  signed overflow = carry into MSB XOR carry out of MSB

Behaviour:
- Reset is asynchronous and active-low. While rst_n = 0, all stage valid bits and all registered outputs (out_valid, sum, cout, zero, neg, ovf) are 0.
- On reset deassertion, in_ready = 1.
- Operand conditioning at stage 0:
  - b_eff = sub ? ~b : b
  - c0 = cin XOR sub
- Stage k (0..STAGES-1):
  - adds chunk k of a and b_eff plus the incoming carry;
  - registers the partial sum chunk and the outgoing carry;
  - carries the remaining unprocessed upper chunks of a and b_eff forward in its pipeline register.
  - Chunks already summed travel forward unchanged.
- Final stage:
  - records the carry into the MSB for ovf;
  - computes zero and neg from the complete sum;
  - registers everything into the output register.
- Latency: a beat accepted in cycle t presents out_valid = 1 in cycle t+STAGES, provided there is no stall.
- Throughput: one beat per cycle.
- Handshake:
  - A beat transfers on the input when in_valid && in_ready.
  - It transfers on the output when out_valid && out_ready.
  - out_valid and the output data are held stable while out_valid && !out_ready.
- Stall: the whole pipeline is a single enable, adv = !out_valid || out_ready.
  - in_ready = adv (combinational, no path from in_valid).
  - When adv = 0, no stage register changes.
- Bubbles: when in_valid = 0 on an advancing cycle, a bubble (valid = 0) enters. Bubbles are squeezed out only by advancing; there is no per-stage collapse.
- Simultaneous accept and drain on a full pipe (out_ready = 1, in_valid = 1) is lossless: one beat in, one beat out.
- Wrap-around:
  - 0xFFFF_FFFF + 1 gives sum = 0, cout = 1, zero = 1, ovf = 0.
  - 0x7FFF_FFFF + 1 gives ovf = 1 and neg = 1.
- Reset mid-operation: all in-flight beats are discarded and no partial result is emitted.
- STAGES = 1 degenerates to a single registered adder with latency 1.

Decomposition:
- Package pipe_addsub_pkg holds:
  - typedef flags_t, a packed struct {cout, zero, neg, ovf};
  - the localparam function for CHUNK;
  - an elaboration-time check that WIDTH % STAGES == 0.
- Sub-module add_chunk (parameter W): a combinational W-bit ripple adder with ports a, b, ci, s, co, c_msb.
  - c_msb is the carry into bit W-1.
  - It is instantiated once per stage inside a generate loop.
- Pipeline registers stay in the top module.

Test Plan (WIDTH = 32, STAGES = 4):
- Basic add: a = 0x0000_0005, b = 0x0000_0003, sub = 0, cin = 0, out_ready = 1 → exactly 4 cycles later, sum = 0x0000_0008 and all flags 0.
- Chunk-spanning carry: a = 0xFFFF_FFFF, b = 0x0000_0001 → sum = 0, cout = 1, zero = 1, neg = 0, ovf = 0.
- Subtract and overflow:
  - a = 0x0000_0003, b = 0x0000_0005, sub = 1 → sum = 0xFFFF_FFFE, cout = 0, neg = 1.
  - a = 0x8000_0000, b = 1, sub = 1 → sum = 0x7FFF_FFFF, ovf = 1.
- Back-pressure: stream 8 back-to-back beats with out_ready = 0 for 6 cycles mid-stream → in_ready drops once out_valid is held; output is held stable; all 8 results arrive in order with no loss or duplication.
- Bubbles and random: random in_valid/out_ready at 50% over 10k beats → scoreboard matches a reference model of {cout, sum} = a + b_eff + c0 and all four flags.
- Reset mid-stream: assert rst_n = 0 asynchronously with 3 beats in flight → out_valid = 0 immediately; after release, in_ready = 1 and no stale result is emitted.
